// File: rtl/calc_port_responder.sv
// Single-port calc responder: two-beat command/operand request, add/sub/shift
// execution after a fixed latency, one-cycle response with data.
module calc_port_responder #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic [0:3]       cmd_in,
    input  logic [0:WIDTH-1] data_in,
    output logic [0:1]       out_resp,
    output logic [0:WIDTH-1] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, OPND2, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH+1:0] result;

    // Returns {resp[1:0], data}; overflow, underflow and invalid commands return zero data.
    function automatic logic [WIDTH+1:0] execute(input logic [3:0]       cmd,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        logic [4:0]     sh;
        sum = {1'b0, a} + {1'b0, b};
        sh  = b[4:0];
        case (cmd)
            4'd1: execute = sum[WIDTH] ? {2'd2, {WIDTH{1'b0}}} : {2'd1, sum[WIDTH-1:0]};
            4'd2: execute = (b > a) ? {2'd2, {WIDTH{1'b0}}} : {2'd1, a - b};
            4'd5: execute = {2'd1, a << sh};
            4'd6: execute = {2'd1, a >> sh};
            default: execute = {2'd3, {WIDTH{1'b0}}};
        endcase
    endfunction

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_in != 4'd0) begin
                    cmd_d   = cmd_in;
                    op1_d   = data_in;
                    state_d = OPND2;
                end
            end
            OPND2: begin
                op2_d   = data_in;
                cnt_d   = CNT_LOAD;
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are held at zero outside RESP so the bus never shows stale data.
    always_comb begin
        result   = execute(cmd_q, op1_q, op2_q);
        out_resp = 2'd0;
        out_data = '0;
        busy     = (state_q != IDLE);
        if (state_q == RESP) begin
            out_resp = result[WIDTH+1:WIDTH];
            out_data = result[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: latency, arithmetic boundaries,
// invalid commands, busy-ignore, mid-operation reset and an add-zero sweep.
module tb_calc_port_responder;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 3;

    logic             c_clk = 1'b0;
    logic             reset = 1'b1;
    logic [0:3]       cmd_in = '0;
    logic [0:WIDTH-1] data_in = '0;
    logic [0:1]       out_resp;
    logic [0:WIDTH-1] out_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    calc_port_responder #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .c_clk   (c_clk),
        .reset   (reset),
        .cmd_in  (cmd_in),
        .data_in (data_in),
        .out_resp(out_resp),
        .out_data(out_data),
        .busy    (busy)
    );

    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request; optionally attempt a second command while busy.
    task automatic run_req(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                           input bit inject);
        cmd_in  = cmd;
        data_in = a;
        step();
        check({tag, "_busy_op2"}, busy, 1);
        cmd_in  = '0;
        data_in = b;
        step();
        data_in = '0;
        for (int k = 0; k < LATENCY; k++) begin
            check({tag, "_quiet_resp"}, out_resp, 0);
            check({tag, "_quiet_data"}, out_data, 0);
            if (inject && k == 0) begin
                cmd_in  = 4'd1;
                data_in = 32'h0000_0007;
            end else if (inject && k == 1) begin
                cmd_in  = '0;
                data_in = '0;
            end
            step();
        end
        check({tag, "_resp"}, out_resp, er);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_busy_resp"}, busy, 1);
        step();
        check({tag, "_after_resp"}, out_resp, 0);
        check({tag, "_after_data"}, out_data, 0);
        check({tag, "_after_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("idle_resp", out_resp, 0);
            check("idle_data", out_data, 0);
            check("idle_busy", busy, 0);
            step();
        end

        run_req("add_basic", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 0);
        run_req("add_max_0", 4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF, 0);
        run_req("add_ovf",   4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 0);
        run_req("sub_unf",   4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000, 0);
        run_req("sub_ok",    4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E, 0);
        run_req("sub_same",  4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0000_0000, 0);
        run_req("shl_1",     4'd5, 32'h8000_0001, 32'hFFFF_FFE1, 2'd1, 32'h0000_0002, 0);
        run_req("shl_0",     4'd5, 32'hA5A5_0F0F, 32'hFFFF_FFE0, 2'd1, 32'hA5A5_0F0F, 0);
        run_req("shl_31",    4'd5, 32'h0000_0003, 32'h0000_001F, 2'd1, 32'h8000_0000, 0);
        run_req("shr_31",    4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 0);
        run_req("shr_4",     4'd6, 32'hF000_0000, 32'h0000_0004, 2'd1, 32'h0F00_0000, 0);
        run_req("inv_cmd3",  4'd3, 32'h0000_0001, 32'h0000_0001, 2'd3, 32'h0000_0000, 0);
        run_req("inv_cmd4",  4'd4, 32'h0000_0001, 32'h0000_0001, 2'd3, 32'h0000_0000, 0);
        run_req("inv_cmd15", 4'd15, 32'h0000_0001, 32'h0000_0002, 2'd3, 32'h0000_0000, 0);

        run_req("busy_ign",  4'd1, 32'h0000_0005, 32'h0000_0006, 2'd1, 32'h0000_000B, 1);
        for (int i = 0; i < 6; i++) begin
            check("busy_ign_no2nd", out_resp, 0);
            check("busy_ign_idle", busy, 0);
            step();
        end

        cmd_in  = 4'd1;
        data_in = 32'h0000_0001;
        step();
        cmd_in  = '0;
        data_in = 32'h0000_0001;
        step();
        data_in = '0;
        check("rst_exec_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < LATENCY + 3; i++) begin
            check("rst_no_resp", out_resp, 0);
            check("rst_no_data", out_data, 0);
            check("rst_no_busy", busy, 0);
            step();
        end
        run_req("post_rst", 4'd1, 32'h0000_0002, 32'h0000_0003, 2'd1, 32'h0000_0005, 0);

        for (int x = 1; x <= 10000; x++)
            run_req("sweep", 4'd1, 32'(x), 32'h0, 2'd1, 32'(x), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
